// File: rtl/systolic_mac_pe.sv
// Floating-point MAC processing element for an output-stationary systolic array.
// Operands are multiplied in stage 1 (rounded to storage format) and folded into
// a local accumulator in stage 2. Operands, valid and clear are forwarded east/south.
module systolic_mac_pe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int DW = 1 + EXP_W + MAN_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          in_valid,
    input  logic          acc_clear,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic          fwd_valid,
    output logic          fwd_clear,
    input  logic          drain,
    output logic [DW-1:0] psum_out,
    output logic          psum_valid,
    output logic          busy
);

    localparam int EW = EXP_W + 2;          // signed working exponent width
    localparam int SW = MAN_W + 4;          // hidden bit + mantissa + guard/round/sticky
    localparam int PW = 2 * (MAN_W + 1);    // full significand product width
    localparam logic signed [EW-1:0] EXP_MAX  = EW'(2 ** EXP_W - 1);
    localparam logic signed [EW-1:0] EXP_BIAS = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
    localparam logic [DW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Round a normalised significand (hidden bit set) to nearest-even and pack,
    // saturating to infinity on overflow and flushing underflow to signed zero.
    function automatic logic [DW-1:0] round_pack(input logic sign,
                                                 input logic signed [EW-1:0] exp_in,
                                                 input logic [SW-1:0] sig);
        logic                  up;
        logic [MAN_W+1:0]      man_r;
        logic signed [EW-1:0]  exp_r;
        logic [DW-1:0]         res;
        up    = sig[2] & (sig[1] | sig[0] | sig[3]);
        man_r = {1'b0, sig[SW-1:3]} + {{(MAN_W+1){1'b0}}, up};
        exp_r = exp_in;
        if (man_r[MAN_W+1]) begin
            exp_r = exp_in + EXP_ONE;
            man_r = man_r >> 1;
        end
        if (exp_r >= EXP_MAX) begin
            res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_r <= EXP_ZERO) begin
            res = {sign, {(DW-1){1'b0}}};
        end else begin
            res = {sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
        end
        return res;
    endfunction

    // Floating-point multiply with special-value handling.
    function automatic logic [DW-1:0] fp_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic                 sx, sy, sr;
        logic [EXP_W-1:0]     ex, ey;
        logic [MAN_W-1:0]     mx, my;
        logic                 x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        logic [PW-1:0]        prod;
        logic signed [EW-1:0] e;
        logic [SW-1:0]        sig;
        logic [DW-1:0]        res;
        {sx, ex, mx} = x;
        {sy, ey, my} = y;
        x_zero = (ex == {EXP_W{1'b0}});
        y_zero = (ey == {EXP_W{1'b0}});
        x_inf  = (ex == {EXP_W{1'b1}}) && (mx == {MAN_W{1'b0}});
        y_inf  = (ey == {EXP_W{1'b1}}) && (my == {MAN_W{1'b0}});
        x_nan  = (ex == {EXP_W{1'b1}}) && (mx != {MAN_W{1'b0}});
        y_nan  = (ey == {EXP_W{1'b1}}) && (my != {MAN_W{1'b0}});
        sr     = sx ^ sy;
        prod   = {1'b1, mx} * {1'b1, my};
        e      = $signed({2'b00, ex}) + $signed({2'b00, ey}) - EXP_BIAS;
        // product lies in [1,4): at most one normalising shift
        if (prod[PW-1]) begin
            e   = e + EXP_ONE;
            sig = {prod[PW-1 -: MAN_W+3], |prod[PW-MAN_W-4:0]};
        end else begin
            sig = {prod[PW-2 -: MAN_W+3], |prod[PW-MAN_W-5:0]};
        end
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
            res = QNAN;
        end else if (x_inf || y_inf) begin
            res = {sr, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (x_zero || y_zero) begin
            res = {sr, {(DW-1){1'b0}}};
        end else begin
            res = round_pack(sr, e, sig);
        end
        return res;
    endfunction

    // Floating-point add with guard/round/sticky alignment and special values.
    function automatic logic [DW-1:0] fp_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic                 sx, sy, sb, ss;
        logic [EXP_W-1:0]     ex, ey, eb, es, d;
        logic [MAN_W-1:0]     mx, my, mb, ms;
        logic                 x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        logic [SW-1:0]        big_sig, small_sig, shifted, norm;
        logic [SW:0]          sum;
        logic                 sticky;
        logic signed [EW-1:0] e;
        int                   lz;
        logic [DW-1:0]        res;
        {sx, ex, mx} = x;
        {sy, ey, my} = y;
        x_zero = (ex == {EXP_W{1'b0}});
        y_zero = (ey == {EXP_W{1'b0}});
        x_inf  = (ex == {EXP_W{1'b1}}) && (mx == {MAN_W{1'b0}});
        y_inf  = (ey == {EXP_W{1'b1}}) && (my == {MAN_W{1'b0}});
        x_nan  = (ex == {EXP_W{1'b1}}) && (mx != {MAN_W{1'b0}});
        y_nan  = (ey == {EXP_W{1'b1}}) && (my != {MAN_W{1'b0}});
        // order operands by magnitude so the difference is never negative
        if ({ex, mx} >= {ey, my}) begin
            {sb, eb, mb} = x;
            {ss, es, ms} = y;
        end else begin
            {sb, eb, mb} = y;
            {ss, es, ms} = x;
        end
        d         = eb - es;
        big_sig   = {1'b1, mb, 3'b000};
        small_sig = {1'b1, ms, 3'b000};
        if (int'(d) >= SW) begin
            shifted = {SW{1'b0}};
            sticky  = 1'b1;
        end else begin
            shifted = small_sig >> d;
            sticky  = |(small_sig & ~({SW{1'b1}} << d));
        end
        shifted[0] = shifted[0] | sticky;
        e = $signed({2'b00, eb});
        if (sb == ss) begin
            sum = {1'b0, big_sig} + {1'b0, shifted};
            if (sum[SW]) begin
                norm = {sum[SW:2], sum[1] | sum[0]};
                e    = e + EXP_ONE;
            end else begin
                norm = sum[SW-1:0];
            end
        end else begin
            sum  = {(SW+1){1'b0}};
            norm = big_sig - shifted;
            lz   = 0;
            for (int i = 0; i < SW; i++) begin
                if (norm[i]) lz = SW - 1 - i;
            end
            norm = norm << lz;
            e    = e - EW'(lz);
        end
        if (x_nan || y_nan || (x_inf && y_inf && (sx != sy))) begin
            res = QNAN;
        end else if (x_inf) begin
            res = x;
        end else if (y_inf) begin
            res = y;
        end else if (x_zero && y_zero) begin
            res = {sx & sy, {(DW-1){1'b0}}};
        end else if (x_zero) begin
            res = y;
        end else if (y_zero) begin
            res = x;
        end else if (norm == {SW{1'b0}}) begin
            res = {DW{1'b0}};
        end else begin
            res = round_pack(sb, e, norm);
        end
        return res;
    endfunction

    logic [DW-1:0] a_q, b_q, p1_q, acc_q, psum_q;
    logic [DW-1:0] p1_d, acc_d;
    logic          fv_q, fc_q, v1_q, c1_q, psum_valid_q;

    // Stage-1 product and stage-2 accumulator next state
    always_comb begin
        p1_d  = fp_mul(a_in, b_in);
        acc_d = acc_q;
        if (v1_q) begin
            if (c1_q) begin
                acc_d = p1_q;
            end else begin
                acc_d = fp_add(acc_q, p1_q);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Forwarding, pipeline, accumulator and drain registers; all hold while en=0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q          <= {DW{1'b0}};
            b_q          <= {DW{1'b0}};
            fv_q         <= 1'b0;
            fc_q         <= 1'b0;
            v1_q         <= 1'b0;
            c1_q         <= 1'b0;
            p1_q         <= {DW{1'b0}};
            acc_q        <= {DW{1'b0}};
            psum_q       <= {DW{1'b0}};
            psum_valid_q <= 1'b0;
        end else if (en) begin
            a_q          <= a_in;
            b_q          <= b_in;
            fv_q         <= in_valid;
            fc_q         <= acc_clear;
            v1_q         <= in_valid;
            c1_q         <= acc_clear & in_valid;
            p1_q         <= p1_d;
            acc_q        <= acc_d;
            psum_valid_q <= drain;
            if (drain) psum_q <= acc_d;
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign fwd_valid  = fv_q;
    assign fwd_clear  = fc_q;
    assign psum_out   = psum_q;
    // a pulse held across a stall is only presented on an advancing cycle
    assign psum_valid = psum_valid_q & en;
    assign busy       = v1_q;

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Self-checking bench for systolic_mac_pe (binary16). The reference model works
// on real numbers and applies the rounding/special-value rules directly; the
// accumulator is modelled at transaction level (a drain sees every pair accepted
// on an earlier advancing cycle).
module tb_systolic_mac_pe;

    logic        clk = 1'b0;
    logic        reset, en, in_valid, acc_clear, drain;
    logic [15:0] a_in, b_in, a_out, b_out, psum_out;
    logic        fwd_valid, fwd_clear, psum_valid, busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] macc, e_a, e_b, e_psum;
    logic        e_fv, e_fc, e_pv, e_busy;

    localparam logic [15:0] QN = 16'h7E00;

    systolic_mac_pe #(.EXP_W(5), .MAN_W(10)) dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .acc_clear(acc_clear),
        .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out),
        .fwd_valid(fwd_valid), .fwd_clear(fwd_clear), .drain(drain),
        .psum_out(psum_out), .psum_valid(psum_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic logic is_nan(input logic [15:0] h);
        return (h[14:10] == 5'h1f) && (h[9:0] != 10'h0);
    endfunction
    function automatic logic is_inf(input logic [15:0] h);
        return (h[14:10] == 5'h1f) && (h[9:0] == 10'h0);
    endfunction
    function automatic logic is_zero(input logic [15:0] h);
        return (h[14:10] == 5'h00);
    endfunction

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real mag;
        mag = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
        return h[15] ? -mag : mag;
    endfunction

    // nearest-even rounding of a nonzero real to binary16, flush-to-zero on underflow
    function automatic logic [15:0] r2h(input real r);
        logic s;
        real  a, sc, fl;
        int   e, m;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        sc = a * 1024.0;
        fl = $floor(sc);
        m  = int'(fl);
        if ((sc - fl > 0.5) || ((sc - fl == 0.5) && (m % 2 == 1))) m++;
        if (m == 2048) begin m = 1024; e++; end
        if (e + 15 >= 31) return {s, 5'h1f, 10'h000};
        if (e + 15 <= 0)  return {s, 15'h0000};
        return {s, 5'(e + 15), 10'(m - 1024)};
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] x, input logic [15:0] y);
        logic s;
        s = x[15] ^ y[15];
        if (is_nan(x) || is_nan(y) || (is_inf(x) && is_zero(y)) || (is_inf(y) && is_zero(x))) return QN;
        if (is_inf(x) || is_inf(y))   return {s, 5'h1f, 10'h000};
        if (is_zero(x) || is_zero(y)) return {s, 15'h0000};
        return r2h(h2r(x) * h2r(y));
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] x, input logic [15:0] y);
        real r;
        if (is_nan(x) || is_nan(y)) return QN;
        if (is_inf(x) && is_inf(y) && (x[15] != y[15])) return QN;
        if (is_inf(x)) return x;
        if (is_inf(y)) return y;
        if (is_zero(x) && is_zero(y)) return {x[15] & y[15], 15'h0000};
        if (is_zero(x)) return y;
        if (is_zero(y)) return x;
        r = h2r(x) + h2r(y);
        if (r == 0.0) return 16'h0000;
        return r2h(r);
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a_out"},      a_out,                 e_a);
        chk({tag, ".b_out"},      b_out,                 e_b);
        chk({tag, ".fwd_valid"},  {15'h0, fwd_valid},    {15'h0, e_fv});
        chk({tag, ".fwd_clear"},  {15'h0, fwd_clear},    {15'h0, e_fc});
        chk({tag, ".busy"},       {15'h0, busy},         {15'h0, e_busy});
        chk({tag, ".psum_valid"}, {15'h0, psum_valid},   {15'h0, e_pv});
        chk({tag, ".psum_out"},   psum_out,              e_psum);
    endtask

    task automatic model_reset();
        macc = 16'h0; e_a = 16'h0; e_b = 16'h0; e_psum = 16'h0;
        e_fv = 1'b0; e_fc = 1'b0; e_pv = 1'b0; e_busy = 1'b0;
    endtask

    // one clock: drive inputs, advance, update the model, compare every output
    task automatic step(input string tag, input logic t_en, input logic t_v, input logic t_c,
                        input logic t_d, input logic [15:0] t_a, input logic [15:0] t_b);
        logic [15:0] prod;
        en = t_en; in_valid = t_v; acc_clear = t_c; drain = t_d; a_in = t_a; b_in = t_b;
        @(posedge clk);
        #1;
        if (t_en) begin
            e_a = t_a; e_b = t_b; e_fv = t_v; e_fc = t_c; e_busy = t_v;
            if (t_d) e_psum = macc;
            e_pv = t_d;
            if (t_v) begin
                prod = m_mul(t_a, t_b);
                macc = t_c ? prod : m_add(macc, prod);
            end
        end else begin
            e_pv = 1'b0;
        end
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic do_drain(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    endtask

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        if ($urandom_range(0, 19) == 0) v = 16'($urandom);
        else v = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
        return v;
    endfunction

    logic [15:0] sa [4];
    logic [15:0] sb [4];

    initial begin
        // ---- reset held with random inputs ----
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom); in_valid = 1'($urandom); acc_clear = 1'($urandom);
            drain = 1'($urandom); a_in = 16'($urandom); b_in = 16'($urandom);
            @(posedge clk);
            #1;
            check_all("reset_hold");
        end
        reset = 1'b1;
        step("reset_release", 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'hABCD);
        step("reset_track",   1'b1, 1'b0, 1'b0, 1'b0, 16'h5A5A, 16'h0F0F);

        // ---- basic MAC ----
        step("mac", 1'b1, 1'b1, 1'b1, 1'b0, 16'h4080, 16'h4500);
        step("mac", 1'b1, 1'b1, 1'b0, 1'b0, 16'h4200, 16'hC100);
        idle("mac");
        do_drain("mac");
        chk("mac_sum", psum_out, 16'h4380);
        chk("mac_pulse", {15'h0, psum_valid}, 16'h0001);
        idle("mac");
        chk("mac_pulse_end", {15'h0, psum_valid}, 16'h0000);

        // ---- back-to-back clears ----
        step("b2b", 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h4000);
        step("b2b", 1'b1, 1'b1, 1'b1, 1'b0, 16'h3C00, 16'h3C00);
        idle("b2b");
        do_drain("b2b");
        chk("b2b_sum", psum_out, 16'h3C00);

        // ---- stall: same pairs without and with a 3-cycle stall ----
        sa[0] = 16'h3C00; sb[0] = 16'h4000;
        sa[1] = 16'h4200; sb[1] = 16'h3800;
        sa[2] = 16'hC000; sb[2] = 16'h3A00;
        sa[3] = 16'h4400; sb[3] = 16'h3400;
        for (int run = 0; run < 2; run++) begin
            for (int k = 0; k < 4; k++) begin
                step("stall_seq", 1'b1, 1'b1, (k == 0), 1'b0, sa[k], sb[k]);
                if (run == 1 && k == 1) begin
                    for (int s = 0; s < 3; s++)
                        step("stall_hold", 1'b0, 1'($urandom), 1'($urandom), 1'b1,
                             16'($urandom), 16'($urandom));
                end
            end
            idle("stall_seq");
            do_drain("stall_seq");
            chk("stall_sum", psum_out, 16'h4200);
        end

        // ---- special values ----
        step("spec", 1'b1, 1'b1, 1'b1, 1'b0, 16'h7BFF, 16'h4000);
        do_drain("spec");
        chk("spec_ovf", psum_out, 16'h7C00);
        step("spec", 1'b1, 1'b1, 1'b1, 1'b0, 16'h7C00, 16'h0000);
        do_drain("spec");
        chk("spec_infx0", psum_out, 16'h7E00);
        step("spec", 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h3C00);
        do_drain("spec");
        chk("spec_subn", psum_out, 16'h0000);
        step("spec", 1'b1, 1'b1, 1'b1, 1'b0, 16'h3C00, 16'h3C00);
        step("spec", 1'b1, 1'b1, 1'b0, 1'b0, 16'hBC00, 16'h3C00);
        idle("spec");
        do_drain("spec");
        chk("spec_cancel", psum_out, 16'h0000);

        // ---- drain with in-flight pair, drain does not clear ----
        step("drain_ovl", 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h4200);
        step("drain_ovl", 1'b1, 1'b1, 1'b0, 1'b1, 16'h3C00, 16'h3C00);
        chk("drain_inflight", psum_out, 16'h4600);
        idle("drain_ovl");
        do_drain("drain_ovl");
        chk("drain_keep", psum_out, 16'h4700);
        idle("drain_ovl");
        do_drain("drain_ovl");
        chk("drain_keep2", psum_out, 16'h4700);

        // ---- drain and clear in the same cycle ----
        step("drain_clr", 1'b1, 1'b1, 1'b1, 1'b1, 16'h4400, 16'h3C00);
        chk("drain_clr_old", psum_out, 16'h4700);
        do_drain("drain_clr");
        chk("drain_clr_new", psum_out, 16'h4400);

        // ---- mid-operation reset ----
        step("midrst", 1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h4000);
        en = 1'b1; in_valid = 1'b1; acc_clear = 1'b0; drain = 1'b1; a_in = 16'h4000; b_in = 16'h3C00;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("midrst_async");
        @(posedge clk);
        #1;
        check_all("midrst_hold");
        reset = 1'b1;
        idle("midrst_after");
        idle("midrst_after");

        // ---- randomized traffic ----
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) < 3), ($urandom_range(0, 4) == 0), rnd_op(), rnd_op());
        end
        idle("rand_end");
        do_drain("rand_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
